// File: rtl/gates_using_decoder_if.sv
// Command/result bus for gates_using_decoder: opcode and operands in, decoded gate result out.
// A transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface gates_using_decoder_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sweep;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       onehot;
  logic [WIDTH-1:0] y;
  logic [2:0]       out_op;
  logic             illegal;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op, a, b, sweep, out_ready,
    input  in_ready, out_valid, onehot, y, out_op, illegal, op_count
  );

  modport slave (
    input  in_valid, op, a, b, sweep, out_ready,
    output in_ready, out_valid, onehot, y, out_op, illegal, op_count
  );
endinterface

// File: rtl/gates_using_decoder.sv
// Decodes a binary gate opcode to a one-hot select and evaluates that bitwise gate on
// latched operands; sweep mode steps opcodes 0..6 over the same operands.
module gates_using_decoder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  gates_using_decoder_if.slave    bus,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sweep_q;
  logic [2:0]       cur_op;
  logic [WIDTH-1:0] y_q, gate_y;
  logic [7:0]       onehot_q;
  logic [2:0]       out_op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] op_count_q;
  logic             accept, handoff, sweep_more;

  assign accept     = (state == IDLE) && bus.in_valid;
  assign handoff    = (state == OUT) && bus.out_ready;
  assign sweep_more = sweep_q && (cur_op < 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = EVAL;
      EVAL:    state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = sweep_more ? EVAL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Opcode 7 (and any undefined code) yields an all-zero result.
  always_comb begin
    gate_y = '0;
    case (cur_op)
      3'd0: gate_y = a_q & b_q;
      3'd1: gate_y = a_q | b_q;
      3'd2: gate_y = ~a_q;
      3'd3: gate_y = ~(a_q | b_q);
      3'd4: gate_y = ~(a_q & b_q);
      3'd5: gate_y = a_q ^ b_q;
      3'd6: gate_y = ~(a_q ^ b_q);
      default: gate_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sweep_q    <= 1'b0;
      cur_op     <= 3'd0;
      y_q        <= '0;
      onehot_q   <= 8'h00;
      out_op_q   <= 3'd0;
      illegal_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      if (accept) begin
        a_q     <= bus.a;
        b_q     <= bus.b;
        sweep_q <= bus.sweep;
        cur_op  <= bus.sweep ? 3'd0 : bus.op;
      end
      if (state == EVAL) begin
        y_q       <= gate_y;
        onehot_q  <= 8'h01 << cur_op;
        out_op_q  <= cur_op;
        illegal_q <= (cur_op == 3'd7);
      end
      if (handoff) begin
        op_count_q <= op_count_q + CNT_ONE;
        if (sweep_more) cur_op <= cur_op + 3'd1;
      end
    end
  end

  // in_ready is forced low while rst is held, even though state is already IDLE.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == OUT);
  assign bus.y         = y_q;
  assign bus.onehot    = onehot_q;
  assign bus.out_op    = out_op_q;
  assign bus.illegal   = illegal_q;
  assign bus.op_count  = op_count_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_gates_using_decoder.sv
// Directed bench for gates_using_decoder: a WIDTH=1/CNT_W=8 instance and a WIDTH=4/CNT_W=2 instance.
module tb_gates_using_decoder;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg1, state_dbg2;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];

  gates_using_decoder_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  gates_using_decoder_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  gates_using_decoder #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state_dbg1)
  );
  gates_using_decoder #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_dbg(state_dbg2)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers: present one command for exactly one accept edge
  task automatic send1(input logic [2:0] op, input logic a, input logic b, input logic sw);
    bus1.op = op; bus1.a = a; bus1.b = b; bus1.sweep = sw; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
  endtask

  task automatic run2(input string tag, input logic [2:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] ey, input logic [7:0] eoh,
                      input logic [1:0] ecnt);
    bus2.op = op; bus2.a = a; bus2.b = b; bus2.sweep = 1'b0; bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    step();
    check({tag, "_valid"}, bus2.out_valid, 1);
    check({tag, "_y"}, bus2.y, ey);
    check({tag, "_onehot"}, bus2.onehot, eoh);
    step();
    check({tag, "_count"}, bus2.op_count, ecnt);
    check({tag, "_idle"}, bus2.out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.op = 3'd0; bus1.a = 1'b0; bus1.b = 1'b0;
    bus1.sweep = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.op = 3'd0; bus2.a = 4'h0; bus2.b = 4'h0;
    bus2.sweep = 1'b0; bus2.out_ready = 1'b1;
    step();
    step();

    // reset state
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_y", bus1.y, 0);
    check("rst_onehot", bus1.onehot, 8'h00);
    check("rst_out_op", bus1.out_op, 0);
    check("rst_illegal", bus1.illegal, 0);
    check("rst_op_count", bus1.op_count, 0);
    check("rst_in_ready", bus1.in_ready, 0);
    check("rst_state", state_dbg1, 2'd0);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", bus1.in_ready, 1);

    // single AND, 1&1
    bus1.out_ready = 1'b1;
    send1(3'd0, 1'b1, 1'b1, 1'b0);
    check("and_eval_valid", bus1.out_valid, 0);
    check("and_eval_state", state_dbg1, 2'd1);
    check("and_eval_in_ready", bus1.in_ready, 0);
    step();
    check("and_valid", bus1.out_valid, 1);
    check("and_y", bus1.y, 1);
    check("and_onehot", bus1.onehot, 8'h01);
    check("and_out_op", bus1.out_op, 0);
    check("and_illegal", bus1.illegal, 0);
    step();
    check("and_done_valid", bus1.out_valid, 0);
    check("and_count", bus1.op_count, 1);
    check("and_done_in_ready", bus1.in_ready, 1);

    // sweep with a=1 b=0: AND OR NOT NOR NAND XOR XNOR
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    send1(3'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      logic [3:0] ey;
      logic [7:0] eoh;
      step();
      ey  = exp_q.pop_front();
      eoh = 8'h01 << i;
      check($sformatf("sweep%0d_valid", i), bus1.out_valid, 1);
      check($sformatf("sweep%0d_y", i), bus1.y, ey);
      check($sformatf("sweep%0d_onehot", i), bus1.onehot, eoh);
      check($sformatf("sweep%0d_out_op", i), bus1.out_op, i);
      check($sformatf("sweep%0d_illegal", i), bus1.illegal, 0);
      check($sformatf("sweep%0d_in_ready", i), bus1.in_ready, 0);
      step();
      check($sformatf("sweep%0d_count", i), bus1.op_count, 2 + i);
    end
    check("sweep_done_valid", bus1.out_valid, 0);
    check("sweep_done_in_ready", bus1.in_ready, 1);
    check("sweep_q_empty", exp_q.size(), 0);

    // backpressure on XOR 1^0; a competing command is held on in_valid meanwhile
    bus1.out_ready = 1'b0;
    send1(3'd5, 1'b1, 1'b0, 1'b0);
    step();
    bus1.op = 3'd0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), bus1.out_valid, 1);
      check($sformatf("bp%0d_y", i), bus1.y, 1);
      check($sformatf("bp%0d_onehot", i), bus1.onehot, 8'h20);
      check($sformatf("bp%0d_in_ready", i), bus1.in_ready, 0);
      check($sformatf("bp%0d_count", i), bus1.op_count, 8);
      step();
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b1;
    step();
    check("bp_release_valid", bus1.out_valid, 0);
    check("bp_release_in_ready", bus1.in_ready, 1);
    check("bp_release_count", bus1.op_count, 9);

    // illegal opcode
    send1(3'd7, 1'b1, 1'b1, 1'b0);
    step();
    check("ill_valid", bus1.out_valid, 1);
    check("ill_y", bus1.y, 0);
    check("ill_onehot", bus1.onehot, 8'h80);
    check("ill_out_op", bus1.out_op, 7);
    check("ill_illegal", bus1.illegal, 1);
    step();
    check("ill_count", bus1.op_count, 10);

    // reset after the third sweep result is handed off
    send1(3'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      step();
    end
    check("prerst_count", bus1.op_count, 13);
    rst = 1'b1;
    #1;
    check("midrst_valid", bus1.out_valid, 0);
    check("midrst_y", bus1.y, 0);
    check("midrst_onehot", bus1.onehot, 8'h00);
    check("midrst_out_op", bus1.out_op, 0);
    check("midrst_count", bus1.op_count, 0);
    check("midrst_in_ready", bus1.in_ready, 0);
    step();
    rst = 1'b0;
    step();
    check("postrst_in_ready", bus1.in_ready, 1);
    check("postrst_valid", bus1.out_valid, 0);
    send1(3'd1, 1'b0, 1'b1, 1'b0);
    step();
    check("or_y", bus1.y, 1);
    check("or_onehot", bus1.onehot, 8'h02);
    step();
    check("or_count", bus1.op_count, 1);

    // wide operands, 2-bit counter wrap
    run2("xnor4", 3'd6, 4'b1100, 4'b1010, 4'b1001, 8'h40, 2'd1);
    run2("and4",  3'd0, 4'hF,    4'h3,    4'h3,    8'h01, 2'd2);
    run2("nor4",  3'd3, 4'h0,    4'h0,    4'hF,    8'h08, 2'd3);
    run2("nand4", 3'd4, 4'hF,    4'hF,    4'h0,    8'h10, 2'd0);
    run2("not4",  3'd2, 4'h5,    4'h9,    4'hA,    8'h04, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
